ex_muldiv: RTL and testbench

Iterative multiply/divide unit attached to the EX stage of the MIPS32 pipeline. It executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU over multiple cycles and returns a 2*DATA_W {HI,LO} result. EX holds the pipeline stalled while start_i=1 and ready_o=0. EX forwards the result to the HI/LO write path (whilo/hi/lo) in the cycle ready_o=1.

---
 rtl/ex_muldiv_pkg.sv | 33 +++
 rtl/ex_muldiv_if.sv | 30 +++
 rtl/ex_muldiv_div_step.sv | 28 ++
 rtl/ex_muldiv.sv | 168 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
// Operation codes, FSM state encoding, default operand width and op-class helpers.
// No logic; imported by the interface, the divide step and the top.
package ex_muldiv_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
    localparam logic [2:0] MULDIV_OP_DIV   = 3'd2;
    localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_MADD  = 3'd4;
    localparam logic [2:0] MULDIV_OP_MADDU = 3'd5;
    localparam logic [2:0] MULDIV_OP_MSUB  = 3'd6;
    localparam logic [2:0] MULDIV_OP_MSUBU = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    // Even op codes are the signed variants.
    function automatic logic op_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// master = EX stage (issues requests), slave = ex_muldiv.
// ready_o is a one-cycle completion strobe; EX stalls while start_i=1 and ready_o=0.
interface ex_muldiv_if
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                  start_i;
    logic [2:0]            op_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [DATA_W-1:0]     acc_hi_i;
    logic [DATA_W-1:0]     acc_lo_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;
    logic                  div_by_zero_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, acc_hi_i, acc_lo_i, annul_i,
        input  result_o, ready_o, busy_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, acc_hi_i, acc_lo_i, annul_i,
        output result_o, ready_o, busy_o, div_by_zero_o
    );
endinterface

// File: rtl/ex_muldiv_div_step.sv
// One restoring-division step on unsigned magnitudes: shift, trial subtract, quotient bit.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs each iteration.
module muldiv_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_nxt,
    output logic [DATA_W-1:0] quo_nxt
);
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // rem < divisor on entry, so the shifted value fits DATA_W+1 bits and diff's MSB is its sign.
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[DATA_W]) begin
            rem_nxt = diff[DATA_W-1:0];
            quo_nxt = {quo[DATA_W-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[DATA_W-1:0];
            quo_nxt = {quo[DATA_W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU/MADD(U)/MSUB(U) unit for EX; returns {HI,LO}.
// Latency: DATA_W+1 cycles from accepted start to ready_o; divide-by-zero in 1 cycle.
// No backpressure: ready_o is a one-cycle strobe, start_i only sampled in IDLE, annul_i aborts.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);

    muldiv_state_t          state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             op_q;
    logic [2*DATA_W-1:0]    acc_q;
    logic                   neg_q;      // negate product / quotient
    logic                   neg_r_q;    // negate remainder (dividend was negative)
    logic [DATA_W-1:0]      mcand_q;
    logic [2*DATA_W-1:0]    prod_q;     // {partial high, remaining multiplier bits}
    logic [DATA_W-1:0]      rem_q;
    logic [DATA_W-1:0]      quo_q;
    logic [DATA_W-1:0]      divisor_q;
    logic [2*DATA_W-1:0]    result_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   dbz_q;

    logic                   sgn;
    logic [DATA_W-1:0]      abs1;
    logic [DATA_W-1:0]      abs2;
    logic [DATA_W:0]        mul_sum;
    logic [2*DATA_W-1:0]    prod_nxt;
    logic [2*DATA_W-1:0]    prod_s;
    logic [2*DATA_W-1:0]    mul_res;
    logic [DATA_W-1:0]      rem_nxt;
    logic [DATA_W-1:0]      quo_nxt;
    logic [DATA_W-1:0]      rem_s;
    logic [DATA_W-1:0]      quo_s;

    muldiv_div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (divisor_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // Operand magnitudes for the signed variants; the iteration works on unsigned values only.
    always_comb begin
        sgn  = op_is_signed(bus.op_i);
        abs1 = (sgn && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
        abs2 = (sgn && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    end

    // Shift-add step plus the final sign fix-up and accumulate, used on the last iteration.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_nxt = {mul_sum, prod_q[DATA_W-1:1]};
        prod_s   = neg_q ? -prod_nxt : prod_nxt;
        case (op_q)
            MULDIV_OP_MADD, MULDIV_OP_MADDU: mul_res = acc_q + prod_s;
            MULDIV_OP_MSUB, MULDIV_OP_MSUBU: mul_res = acc_q - prod_s;
            default:                         mul_res = prod_s;
        endcase
        quo_s = neg_q   ? -quo_nxt : quo_nxt;
        rem_s = neg_r_q ? -rem_nxt : rem_nxt;
    end

    // Control FSM with registered result/ready/busy/div-by-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            neg_r_q   <= 1'b0;
            mcand_q   <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        op_q    <= bus.op_i;
                        acc_q   <= {bus.acc_hi_i, bus.acc_lo_i};
                        cnt     <= CNT_W'(DATA_W - 1);
                        neg_q   <= sgn & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                        neg_r_q <= sgn & bus.opdata1_i[DATA_W-1];
                        if (op_is_div(bus.op_i)) begin
                            if (bus.opdata2_i == '0) begin
                                result_q <= {bus.opdata1_i, {DATA_W{1'b1}}};
                                ready_q  <= 1'b1;
                                dbz_q    <= 1'b1;
                                state    <= ST_DONE;
                            end else begin
                                rem_q     <= '0;
                                quo_q     <= abs1;
                                divisor_q <= abs2;
                                busy_q    <= 1'b1;
                                state     <= ST_DIV;
                            end
                        end else begin
                            mcand_q <= abs1;
                            prod_q  <= {{DATA_W{1'b0}}, abs2};
                            busy_q  <= 1'b1;
                            state   <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (bus.annul_i) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        prod_q <= prod_nxt;
                        if (cnt == '0) begin
                            result_q <= mul_res;
                            ready_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                ST_DIV: begin
                    if (bus.annul_i) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        if (cnt == '0) begin
                            result_q <= {rem_s, quo_s};
                            ready_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // An annul landing on the DONE cycle suppresses that cycle's completion strobe.
    assign bus.result_o      = result_q;
    assign bus.ready_o       = ready_q & ~bus.annul_i;
    assign bus.div_by_zero_o = dbz_q & ~bus.annul_i;
    assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected {result, dbz, ready cycle};
// a negedge monitor pops and compares on every ready_o.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    ex_muldiv_if #(.DATA_W(32)) bus();

    ex_muldiv #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ready_o strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.ready_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: ready_o=1 with nothing outstanding, result 0x%016h (cycle %0d)",
                         bus.result_o, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_result"}, bus.result_o, e.res);
                check({e.name, "_dbz"}, 64'(bus.div_by_zero_o), 64'(e.dbz));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive a request for one cycle; optionally register its expected completion.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi, input logic [31:0] lo,
                            input bit expect_done, input logic [63:0] res, input logic dbz,
                            input int lat, input string name);
        exp_t e;
        bus.start_i   = 1'b1;
        bus.op_i      = op;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.acc_hi_i  = hi;
        bus.acc_lo_i  = lo;
        if (expect_done) begin
            e.res  = res;
            e.dbz  = dbz;
            e.cyc  = cyc + lat;
            e.name = name;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    // Wait for ready_o (bounded), then step into the following IDLE cycle.
    task automatic wait_ready(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o === 1'b1) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: ready_o=0 after 40 cycles, expected a completion", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 time units, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i   = 1'b0;
        bus.op_i      = '0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.acc_hi_i  = '0;
        bus.acc_lo_i  = '0;
        bus.annul_i   = 1'b0;

        // Reset state
        idle_cycles(3);
        check("rst_result", bus.result_o, 64'h0);
        check("rst_ready", 64'(bus.ready_o), 64'h0);
        check("rst_busy", 64'(bus.busy_o), 64'h0);
        check("rst_dbz", 64'(bus.div_by_zero_o), 64'h0);
        rst = 1'b0;
        idle_cycles(1);

        // MULTU max*max, with a start pulse while busy that must be ignored
        start_op(MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1,
                 64'hFFFF_FFFE_0000_0001, 0, 33, "multu_max");
        check("busy_in_mul", 64'(bus.busy_o), 64'h1);
        start_op(MULDIV_OP_DIVU, 32'd5, 32'd0, 0, 0, 0, 0, 0, 0, "ignored");
        wait_ready("multu_max");

        // Back-to-back: MULT ignores acc, MADD / MADDU / MSUB / MSUBU accumulate
        start_op(MULDIV_OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'h1234_5678, 32'h9ABC_DEF0, 1,
                 64'hFFFF_FFFF_FFFF_FFF1, 0, 33, "mult_neg");
        wait_ready("mult_neg");
        start_op(MULDIV_OP_MADD, 32'd2, 32'd3, 32'd1, 32'd0, 1,
                 64'h0000_0001_0000_0006, 0, 33, "madd");
        wait_ready("madd");
        start_op(MULDIV_OP_MSUB, 32'd3, 32'd4, 32'd0, 32'd10, 1,
                 64'hFFFF_FFFF_FFFF_FFFE, 0, 33, "msub");
        wait_ready("msub");
        start_op(MULDIV_OP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1,
                 64'h0000_0001_0000_0000, 0, 33, "maddu_carry");
        wait_ready("maddu_carry");
        start_op(MULDIV_OP_MSUBU, 32'd1, 32'd1, 32'd1, 32'd0, 1,
                 64'h0000_0000_FFFF_FFFF, 0, 33, "msubu_borrow");
        wait_ready("msubu_borrow");

        // Divides
        start_op(MULDIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 1,
                 64'hFFFF_FFFF_FFFF_FFFD, 0, 33, "div_neg");
        wait_ready("div_neg");
        start_op(MULDIV_OP_DIVU, 32'd100, 32'd7, 0, 0, 1,
                 64'h0000_0002_0000_000E, 0, 33, "divu");
        wait_ready("divu");
        start_op(MULDIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1,
                 64'h0000_0000_8000_0000, 0, 33, "div_ovf");
        wait_ready("div_ovf");
        start_op(MULDIV_OP_DIVU, 32'd5, 32'd0, 0, 0, 1,
                 64'h0000_0005_FFFF_FFFF, 1, 1, "divu_zero");
        wait_ready("divu_zero");
        check("dbz_clears", 64'(bus.div_by_zero_o), 64'h0);

        // annul together with start in IDLE: nothing starts
        bus.annul_i = 1'b1;
        start_op(MULDIV_OP_MULT, 32'd7, 32'd9, 0, 0, 0, 0, 0, 0, "annul_start");
        bus.annul_i = 1'b0;
        check("annul_start_busy", 64'(bus.busy_o), 64'h0);

        // annul at cycle 10 of a MULT: back to IDLE, result unchanged, no ready
        start_op(MULDIV_OP_MULT, 32'd7, 32'd9, 0, 0, 0, 0, 0, 0, "annul_mul");
        idle_cycles(9);
        bus.annul_i = 1'b1;
        idle_cycles(1);
        bus.annul_i = 1'b0;
        check("annul_busy", 64'(bus.busy_o), 64'h0);
        check("annul_result_held", bus.result_o, 64'h0000_0005_FFFF_FFFF);
        idle_cycles(40);
        start_op(MULDIV_OP_MULTU, 32'd6, 32'd7, 0, 0, 1,
                 64'd42, 0, 33, "after_annul");
        wait_ready("after_annul");

        // Reset at cycle 5 of a DIV aborts it and clears every output
        start_op(MULDIV_OP_DIVU, 32'd100, 32'd7, 0, 0, 0, 0, 0, 0, "rst_div");
        idle_cycles(4);
        rst = 1'b1;
        idle_cycles(1);
        check("midrst_result", bus.result_o, 64'h0);
        check("midrst_ready", 64'(bus.ready_o), 64'h0);
        check("midrst_busy", 64'(bus.busy_o), 64'h0);
        check("midrst_dbz", 64'(bus.div_by_zero_o), 64'h0);
        rst = 1'b0;
        idle_cycles(40);
        start_op(MULDIV_OP_MULT, 32'd2, 32'hFFFF_FFFC, 0, 0, 1,
                 64'hFFFF_FFFF_FFFF_FFF8, 0, 33, "after_rst");
        wait_ready("after_rst");

        idle_cycles(3);
        check("outstanding", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
